// File: rtl/seven_segment_capture.sv
// seven_segment_capture
// Recovers four 4-bit digit codes by watching a multiplexed, active-low
// seven-segment display scan. Each scanned sample (segments + digit enables)
// is registered, and a digit is committed into its slot only after the same
// selectable sample has been seen for STABLE_CYCLES consecutive edges.
// Optional decimal-point capture is enabled by defining the macro
// SEVEN_SEGMENT_CAPTURE_DP_EN (adds input dp and output dp_flags).
module seven_segment_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:7]  seg,
  input  logic [3:0]  an,
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
  input  logic        dp,
  output logic [3:0]  dp_flags,
`endif
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        pattern_err
);

  // Run counter saturates at this value; 8 bits covers the legal 2..255 range.
  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
  localparam int SAMPLE_W = 12;
`else
  localparam int SAMPLE_W = 11;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    HELD  = 2'b10
  } state_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // A sample is selectable only when exactly one digit enable is low.
  function automatic logic is_selectable(input logic [3:0] a);
    logic r;
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Slot index of the single low digit enable (0 when not selectable).
  function automatic logic [1:0] slot_of(input logic [3:0] a);
    logic [1:0] r;
    case (a)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Segment pattern (a..g, active-low) to {legal, code}.
  function automatic logic [4:0] decode_seg(input logic [1:7] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      7'b1111111: r = {1'b1, 4'd10};
      7'b0110000: r = {1'b1, 4'd12};
      7'b1111110: r = {1'b1, 4'd15};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic [SAMPLE_W-1:0] sample_s;
  logic [SAMPLE_W-1:0] sample_r;
  logic [1:7]          seg_held_s;
  logic [3:0]          an_held_s;
  logic                sel_new_s;
  logic                same_s;
  logic [7:0]          run_r;
  logic [7:0]          run_nxt_s;
  state_t              state_r;
  state_t              state_nxt_s;
  logic                commit_s;
  logic [1:0]          slot_s;
  logic [4:0]          dec_s;
  logic                legal_s;
  logic [3:0]          code_s;

  logic [15:0]         digits_r;
  logic [3:0]          valid_r;
  logic [3:0]          mask_r;
  logic                frame_r;
  logic                perr_r;
  logic [15:0]         digits_nxt_s;
  logic [3:0]          valid_nxt_s;
  logic [3:0]          mask_set_s;
  logic [3:0]          mask_nxt_s;
  logic                frame_nxt_s;
  logic                perr_nxt_s;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
  logic                dp_held_s;
  logic [3:0]          dpf_r;
  logic [3:0]          dpf_nxt_s;
`endif

  // ---------------------------------------------------------------------
  // Sample comparison and run length
  // ---------------------------------------------------------------------
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
  assign sample_s  = {dp, seg, an};
  assign dp_held_s = sample_r[11];
`else
  assign sample_s  = {seg, an};
`endif
  assign seg_held_s = sample_r[10:4];
  assign an_held_s  = sample_r[3:0];

  assign sel_new_s = is_selectable(an);
  assign same_s    = (sample_s == sample_r);

  // Commit decisions look only at the registered sample and its run length.
  assign commit_s = (state_r == COUNT) && (run_r == RUN_MAX);
  assign slot_s   = slot_of(an_held_s);
  assign dec_s    = decode_seg(seg_held_s);
  assign legal_s  = dec_s[4];
  assign code_s   = dec_s[3:0];

  // Next run length: extend a matching selectable run, otherwise restart.
  always_comb begin
    run_nxt_s = 8'd0;
    if (sel_new_s && same_s) begin
      if (run_r < RUN_MAX) begin
        run_nxt_s = run_r + 8'd1;
      end else begin
        run_nxt_s = RUN_MAX;
      end
    end else if (sel_new_s) begin
      run_nxt_s = 8'd1;
    end else begin
      run_nxt_s = 8'd0;
    end
  end

  // Next FSM state: any change leaves HELD; a commit moves COUNT to HELD.
  always_comb begin
    state_nxt_s = state_r;
    if (!sel_new_s) begin
      state_nxt_s = IDLE;
    end else if (!same_s) begin
      state_nxt_s = COUNT;
    end else if (commit_s || (state_r == HELD)) begin
      state_nxt_s = HELD;
    end else begin
      state_nxt_s = COUNT;
    end
  end

  // Sample register, run counter and FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_r <= {SAMPLE_W{1'b1}};
      run_r    <= 8'd0;
      state_r  <= IDLE;
    end else begin
      sample_r <= sample_s;
      run_r    <= run_nxt_s;
      state_r  <= state_nxt_s;
    end
  end

  // ---------------------------------------------------------------------
  // Commit: slot update, frame mask and status pulses
  // ---------------------------------------------------------------------

  // Compute next slot contents, frame mask and pulses for this edge.
  always_comb begin
    digits_nxt_s = digits_r;
    valid_nxt_s  = valid_r;
    mask_set_s   = mask_r;
    mask_nxt_s   = mask_r;
    frame_nxt_s  = 1'b0;
    perr_nxt_s   = 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
    dpf_nxt_s    = dpf_r;
`endif
    if (commit_s) begin
      if (legal_s) begin
        digits_nxt_s[{slot_s, 2'b00} +: 4] = code_s;
        valid_nxt_s[slot_s]                = 1'b1;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
        dpf_nxt_s[slot_s]                  = ~dp_held_s;
`endif
        // Re-committing a slot already in the mask simply keeps its bit set.
        mask_set_s = mask_r | (4'b0001 << slot_s);
        if (mask_set_s == 4'b1111) begin
          frame_nxt_s = 1'b1;
          mask_nxt_s  = 4'b0000;
        end else begin
          frame_nxt_s = 1'b0;
          mask_nxt_s  = mask_set_s;
        end
      end else begin
        // Unknown pattern: flag it, leave every slot and the mask alone.
        perr_nxt_s = 1'b1;
      end
    end else begin
      frame_nxt_s = 1'b0;
      perr_nxt_s  = 1'b0;
    end
  end

  // Output and frame-mask registers; reset dominates a same-edge commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_r <= 16'h0000;
      valid_r  <= 4'b0000;
      mask_r   <= 4'b0000;
      frame_r  <= 1'b0;
      perr_r   <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
      dpf_r    <= 4'b0000;
`endif
    end else begin
      digits_r <= digits_nxt_s;
      valid_r  <= valid_nxt_s;
      mask_r   <= mask_nxt_s;
      frame_r  <= frame_nxt_s;
      perr_r   <= perr_nxt_s;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
      dpf_r    <= dpf_nxt_s;
`endif
    end
  end

  assign digits      = digits_r;
  assign digit_valid = valid_r;
  assign frame_done  = frame_r;
  assign pattern_err = perr_r;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
  assign dp_flags    = dpf_r;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Self-checking bench for seven_segment_capture (STABLE_CYCLES = 4).
// Each scenario task drives rows of (seg, an, cycles); rows long enough to
// commit push the expected post-commit outputs into a scoreboard queue, and
// every edge the outputs are compared against the popped or held expectation.
`timescale 1ns/1ps
module tb_seven_segment_capture;

  localparam int SC = 4;
  localparam logic [1:7] BLANK_SEG = 7'b1111111;
  localparam logic [3:0] BLANK_AN  = 4'b1111;

  typedef struct {
    logic [1:7] s;
    logic [3:0] a;
    int         n;
  } row_t;

  typedef struct {
    int          edge_no;
    logic [15:0] d;
    logic [3:0]  v;
    logic        fd;
    logic        pe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:7]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        pattern_err;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
  logic        dp;
  logic [3:0]  dp_flags;
`endif

  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic [3:0]  m_mask;
  logic [15:0] exp_digits;
  logic [3:0]  exp_valid;
  logic        exp_fd;
  logic        exp_pe;

  seven_segment_capture #(.STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
    .dp          (dp),
    .dp_flags    (dp_flags),
`endif
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  // Reference decode table: returns {legal, code}.
  function automatic logic [4:0] ref_decode(input logic [1:7] s);
    logic [1:7] pats [13];
    int         codes [13];
    logic [4:0] r;
    pats  = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
              7'b1111111, 7'b0110000, 7'b1111110};
    codes = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 15};
    r = 5'b00000;
    for (int i = 0; i < 13; i++) begin
      if (pats[i] == s) r = {1'b1, 4'(codes[i])};
    end
    return r;
  endfunction

  // Slot selected by the digit enables, or -1 when not exactly one is low.
  function automatic int ref_slot(input logic [3:0] a);
    int k;
    int zeros;
    k = -1;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!a[i]) begin
        zeros++;
        k = i;
      end
    end
    return (zeros == 1) ? k : -1;
  endfunction

  // Push the expected outcome of a row that starts on the next edge.
  // Every row differs from the sample before it, so its run starts at 1.
  task automatic schedule_row(input row_t r);
    exp_t       e;
    int         k;
    logic [4:0] dc;
    k = ref_slot(r.a);
    if (k >= 0 && r.n >= SC) begin
      dc = ref_decode(r.s);
      e.edge_no = cyc + 1 + SC;
      e.fd = 1'b0;
      e.pe = 1'b0;
      if (dc[4]) begin
        m_digits[4*k +: 4] = dc[3:0];
        m_valid[k] = 1'b1;
        m_mask[k]  = 1'b1;
        if (m_mask == 4'b1111) begin
          e.fd   = 1'b1;
          m_mask = 4'b0000;
        end
      end else begin
        e.pe = 1'b1;
      end
      e.d = m_digits;
      e.v = m_valid;
      sb.push_back(e);
    end
  endtask

  // Load the expectation for the current edge (pulses low unless scheduled).
  task automatic pop_expected();
    exp_t e;
    exp_fd = 1'b0;
    exp_pe = 1'b0;
    if (sb.size() != 0 && sb[0].edge_no == cyc) begin
      e = sb.pop_front();
      exp_digits = e.d;
      exp_valid  = e.v;
      exp_fd     = e.fd;
      exp_pe     = e.pe;
    end
  endtask

  // Apply one sample for one clock and settle just after the edge.
  task automatic drive(input logic [1:7] s, input logic [3:0] a);
    seg = s;
    an  = a;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(7'b0000001, 4'b1110);
      checks++;
      if ({digits, digit_valid, frame_done, pattern_err} !== 22'd0) begin
        errors++;
        $display("FAIL reset edge=%0d observed d=%h v=%b fd=%b pe=%b expected all zero",
                 cyc, digits, digit_valid, frame_done, pattern_err);
      end
    end
    rst_n = 1'b1;
    m_digits = 16'h0000; m_valid = 4'b0000; m_mask = 4'b0000;
    exp_digits = 16'h0000; exp_valid = 4'b0000;
    sb.delete();
  endtask

  task automatic test_single_digit();
    row_t rows[$];
    int   first_valid;
    first_valid = -1;
    rows.push_back('{7'b0010010, 4'b1110, 6});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    rows.push_back('{7'b0010010, 4'b1110, 20});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    foreach (rows[r]) begin
      schedule_row(rows[r]);
      for (int i = 0; i < rows[r].n; i++) begin
        drive(rows[r].s, rows[r].a);
        pop_expected();
        checks++;
        if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
          errors++;
          $display("FAIL single_digit edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                   cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
        end
        if (r == 0 && first_valid < 0 && digit_valid[0] === 1'b1) first_valid = i + 1;
      end
    end
    checks++;
    if (first_valid != SC + 1) begin
      errors++;
      $display("FAIL single_digit_latency observed edge %0d expected edge %0d", first_valid, SC + 1);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_digit_drain observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_frame();
    row_t rows[$];
    int   fd_count;
    int   fd_edge;
    int   fd_want;
    fd_count = 0; fd_edge = -1; fd_want = -2;
    rows.push_back('{7'b0000110, 4'b1110, 8});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    rows.push_back('{7'b1001111, 4'b1101, 8});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    rows.push_back('{7'b1001100, 4'b1011, 8});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    rows.push_back('{7'b0000100, 4'b0111, 8});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    foreach (rows[r]) begin
      if (r == 6) fd_want = cyc + 1 + SC;
      schedule_row(rows[r]);
      for (int i = 0; i < rows[r].n; i++) begin
        drive(rows[r].s, rows[r].a);
        pop_expected();
        checks++;
        if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
          errors++;
          $display("FAIL frame edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                   cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
        end
        if (frame_done === 1'b1) begin
          fd_count++;
          fd_edge = cyc;
        end
      end
    end
    checks++;
    if (digits !== 16'h9413) begin
      errors++;
      $display("FAIL frame_digits observed %h expected 9413", digits);
    end
    checks++;
    if (fd_count != 1 || fd_edge != fd_want) begin
      errors++;
      $display("FAIL frame_pulse observed %0d pulses at edge %0d expected 1 pulse at edge %0d",
               fd_count, fd_edge, fd_want);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL frame_drain observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_illegal();
    row_t        rows[$];
    int          pe_count;
    logic [15:0] d_before;
    logic [3:0]  v_before;
    pe_count = 0;
    d_before = exp_digits;
    v_before = exp_valid;
    rows.push_back('{7'b1010101, 4'b1011, 6});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    foreach (rows[r]) begin
      schedule_row(rows[r]);
      for (int i = 0; i < rows[r].n; i++) begin
        drive(rows[r].s, rows[r].a);
        pop_expected();
        checks++;
        if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
          errors++;
          $display("FAIL illegal edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                   cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
        end
        if (pattern_err === 1'b1) pe_count++;
      end
    end
    checks++;
    if (pe_count != 1 || digits !== d_before || digit_valid !== v_before) begin
      errors++;
      $display("FAIL illegal_summary observed pulses=%0d d=%h v=%b expected pulses=1 d=%h v=%b",
               pe_count, digits, digit_valid, d_before, v_before);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL illegal_drain observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_glitch();
    row_t rows[$];
    int   glitch_end;
    int   commit_edge;
    glitch_end = -1; commit_edge = -1;
    rows.push_back('{7'b0000000, 4'b1101, 3});
    rows.push_back('{7'b1111110, 4'b1101, 1});
    rows.push_back('{7'b0000000, 4'b1101, 5});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    foreach (rows[r]) begin
      if (r == 2) glitch_end = cyc + 1;
      schedule_row(rows[r]);
      for (int i = 0; i < rows[r].n; i++) begin
        drive(rows[r].s, rows[r].a);
        pop_expected();
        checks++;
        if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
          errors++;
          $display("FAIL glitch edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                   cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
        end
        if (commit_edge < 0 && digits[7:4] === 4'd8) commit_edge = cyc;
      end
    end
    checks++;
    if (commit_edge != glitch_end + SC) begin
      errors++;
      $display("FAIL glitch_latency observed edge %0d expected edge %0d", commit_edge, glitch_end + SC);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL glitch_drain observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_multi_select();
    row_t        rows[$];
    logic [15:0] d_before;
    logic [3:0]  v_before;
    d_before = exp_digits;
    v_before = exp_valid;
    rows.push_back('{7'b0000001, 4'b0011, 10});
    rows.push_back('{BLANK_SEG, BLANK_AN, 3});
    foreach (rows[r]) begin
      schedule_row(rows[r]);
      for (int i = 0; i < rows[r].n; i++) begin
        drive(rows[r].s, rows[r].a);
        pop_expected();
        checks++;
        if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
          errors++;
          $display("FAIL multi_select edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                   cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
        end
      end
    end
    checks++;
    if (digits !== d_before || digit_valid !== v_before) begin
      errors++;
      $display("FAIL multi_select_unchanged observed d=%h v=%b expected d=%h v=%b",
               digits, digit_valid, d_before, v_before);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    int   fd_count;
    fd_count = 0;
    rows.push_back('{7'b1001100, 4'b1011, SC});
    rows.push_back('{7'b0001111, 4'b0111, SC});
    rows.push_back('{7'b0100100, 4'b1110, SC});
    rows.push_back('{BLANK_SEG, BLANK_AN, 6});
    foreach (rows[r]) begin
      schedule_row(rows[r]);
      for (int i = 0; i < rows[r].n; i++) begin
        drive(rows[r].s, rows[r].a);
        pop_expected();
        checks++;
        if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
          errors++;
          $display("FAIL back_to_back edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                   cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
        end
        if (frame_done === 1'b1) fd_count++;
      end
    end
    checks++;
    if (fd_count != 1) begin
      errors++;
      $display("FAIL back_to_back_frame observed %0d pulses expected 1", fd_count);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midrun();
    row_t rows[$];
    int   first_valid;
    first_valid = -1;
    // Three identical samples: run reaches 3, no commit yet.
    for (int i = 0; i < 3; i++) begin
      drive(7'b0000001, 4'b1110);
      pop_expected();
      checks++;
      if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
        errors++;
        $display("FAIL reset_midrun_pre edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                 cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
      end
    end
    rst_n = 1'b0;
    drive(7'b0000001, 4'b1110);
    rst_n = 1'b1;
    m_digits = 16'h0000; m_valid = 4'b0000; m_mask = 4'b0000;
    exp_digits = 16'h0000; exp_valid = 4'b0000;
    checks++;
    if ({digits, digit_valid, frame_done, pattern_err} !== 22'd0) begin
      errors++;
      $display("FAIL reset_midrun_clear edge=%0d observed d=%h v=%b fd=%b pe=%b expected all zero",
               cyc, digits, digit_valid, frame_done, pattern_err);
    end
    rows.push_back('{7'b0000001, 4'b1110, 6});
    rows.push_back('{BLANK_SEG, BLANK_AN, 4});
    foreach (rows[r]) begin
      schedule_row(rows[r]);
      for (int i = 0; i < rows[r].n; i++) begin
        drive(rows[r].s, rows[r].a);
        pop_expected();
        checks++;
        if ({digits, digit_valid, frame_done, pattern_err} !== {exp_digits, exp_valid, exp_fd, exp_pe}) begin
          errors++;
          $display("FAIL reset_midrun edge=%0d observed d=%h v=%b fd=%b pe=%b expected d=%h v=%b fd=%b pe=%b",
                   cyc, digits, digit_valid, frame_done, pattern_err, exp_digits, exp_valid, exp_fd, exp_pe);
        end
        if (r == 0 && first_valid < 0 && digit_valid[0] === 1'b1) first_valid = i + 1;
      end
    end
    checks++;
    if (first_valid != SC + 1) begin
      errors++;
      $display("FAIL reset_midrun_latency observed edge %0d expected edge %0d", first_valid, SC + 1);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_midrun_drain observed %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    seg   = BLANK_SEG;
    an    = BLANK_AN;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
    dp    = 1'b1;
`endif
    test_reset();
    test_single_digit();
    test_frame();
    test_illegal();
    test_glitch();
    test_multi_select();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
